// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: time-multiplexes an 8-digit display. Each digit slot is
// ON_CYC cycles driven plus GAP_CYC blanked cycles. The block also runs a frame-based
// blink phase generator.
module display_scan_scheduler #(
  parameter int unsigned ON_CYC       = 250000,
  parameter int unsigned GAP_CYC      = 2500,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] digit_mask,
  input  logic [7:0] blink_mask,
  input  logic       blink_en,
  output logic [2:0] sel,
  output logic       blank,
  output logic       frame_done,
  output logic       blink_phase
);

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned FCNT_W = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_CYC - 32'd1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((GAP_CYC == 32'd0) ? 32'd0 : GAP_CYC - 32'd1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 32'd1);
  localparam bit                HAS_GAP   = (GAP_CYC != 32'd0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic              blank_nxt;
  logic              frame_done_nxt;
  logic              phase_nxt;
  logic              slot_end;

  // Next-state, slot/frame sequencing and look-ahead blanking
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sel_nxt        = sel;
    fcnt_nxt       = fcnt;
    phase_nxt      = blink_phase;
    frame_done_nxt = 1'b0;
    slot_end       = 1'b0;
    blank_nxt      = 1'b1;

    case (state)
      IDLE: begin
        sel_nxt = '0;
        cnt_nxt = '0;
        if (en) state_nxt = ON;
      end
      ON: begin
        if (cnt == ON_LAST) begin
          cnt_nxt = '0;
          if (HAS_GAP) state_nxt = GAP;
          else         slot_end  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ON;
          slot_end  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sel_nxt   = '0;
      end
    endcase

    if (slot_end) begin
      sel_nxt        = sel + SEL_W'(1);
      frame_done_nxt = (sel == SEL_W'(7));
    end

    if (frame_done_nxt) begin
      if (fcnt == FCNT_LAST) begin
        fcnt_nxt  = '0;
        phase_nxt = ~blink_phase;
      end else begin
        fcnt_nxt = fcnt + FCNT_W'(1);
      end
    end

    if (!blink_en) begin
      fcnt_nxt  = '0;
      phase_nxt = 1'b0;
    end

    // Disabling wins over any boundary occurring in the same cycle
    if (!en) begin
      state_nxt      = IDLE;
      cnt_nxt        = '0;
      sel_nxt        = '0;
      fcnt_nxt       = '0;
      phase_nxt      = 1'b0;
      frame_done_nxt = 1'b0;
    end

    blank_nxt = (state_nxt != ON) ||
                !(digit_mask[sel_nxt] && !(blink_en && blink_mask[sel_nxt] && phase_nxt));
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      fcnt        <= '0;
      sel         <= '0;
      blank       <= 1'b1;
      frame_done  <= 1'b0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      fcnt        <= fcnt_nxt;
      sel         <= sel_nxt;
      blank       <= blank_nxt;
      frame_done  <= frame_done_nxt;
      blink_phase <= phase_nxt;
    end
  end

endmodule
